// File: rtl/cu_immediate_unit.sv
// cu_immediate_unit: pipelined immediate generator with prefix support.
// Pulls the 8-bit or 11-bit immediate out of a 16-bit instruction, extends it
// to DATA_W and holds it in a one-stage output register with valid/ready.
// A PREFIX instruction parks 11 upper bits that are glued onto the next
// immediate so that wide constants can be built.
module cu_immediate_unit #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAG_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic [2:0]        in_imm_src,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_prefixed,
    output logic              prefix_pending,
    output logic              prefix_overwrite
);

    // Extension is done at the widest legal DATA_W, then truncated.
    localparam int unsigned EXT_W = 32;
    localparam int unsigned PFX_W = 11;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_PREFIXED = 1'b1;

    localparam logic [2:0] SRC_SEXT8   = 3'b000;
    localparam logic [2:0] SRC_ZEXT8   = 3'b001;
    localparam logic [2:0] SRC_SEXT11  = 3'b010;
    localparam logic [2:0] SRC_ZEXT11  = 3'b011;
    localparam logic [2:0] SRC_PREFIX  = 3'b100;

    logic [0:0]        state_q,     state_d;
    logic [PFX_W-1:0]  prefix_q,    prefix_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_imm_q,   out_imm_d;
    logic [TAG_W-1:0]  out_tag_q,   out_tag_d;
    logic              out_pfx_q,   out_pfx_d;
    logic              ovw_q,       ovw_d;

    logic [7:0]        imm8;
    logic [10:0]       imm11;
    logic [EXT_W-1:0]  ext_imm;
    logic              pending;
    logic              accept;

    assign imm8    = {in_instr[12:8], in_instr[4:2]};
    assign imm11   = {in_instr[7:5], in_instr[12:8], in_instr[4:2]};
    assign pending = (state_q == ST_PREFIXED);

    // One-stage pipeline: accept whenever the output slot is empty or draining.
    assign in_ready = !reset && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Build the extended immediate, with or without the parked prefix bits.
    always_comb begin
        ext_imm = '0;
        case (in_imm_src)
            SRC_SEXT8:  ext_imm = pending ? {{13{prefix_q[10]}}, prefix_q, imm8}
                                          : {{24{imm8[7]}}, imm8};
            SRC_ZEXT8:  ext_imm = pending ? {13'b0, prefix_q, imm8}
                                          : {24'b0, imm8};
            SRC_SEXT11: ext_imm = pending ? {{10{prefix_q[10]}}, prefix_q, imm11}
                                          : {{21{imm11[10]}}, imm11};
            SRC_ZEXT11: ext_imm = pending ? {10'b0, prefix_q, imm11}
                                          : {21'b0, imm11};
            default:    ext_imm = '0;
        endcase
    end

    // Next-state and output-register logic; flush wins over any accept.
    always_comb begin
        state_d     = state_q;
        prefix_d    = prefix_q;
        out_valid_d = out_valid_q && !out_ready;
        out_imm_d   = out_imm_q;
        out_tag_d   = out_tag_q;
        out_pfx_d   = out_pfx_q;
        ovw_d       = 1'b0;

        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
        end else if (accept) begin
            case (in_imm_src)
                SRC_PREFIX: begin
                    prefix_d = imm11;
                    state_d  = ST_PREFIXED;
                    ovw_d    = pending;
                end
                SRC_SEXT8, SRC_ZEXT8, SRC_SEXT11, SRC_ZEXT11: begin
                    out_valid_d = 1'b1;
                    out_imm_d   = DATA_W'(ext_imm);
                    out_tag_d   = in_tag;
                    out_pfx_d   = pending;
                    state_d     = ST_IDLE;
                end
                default: begin
                    out_valid_d = 1'b1;
                    out_imm_d   = '0;
                    out_tag_d   = in_tag;
                    out_pfx_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prefix_q    <= '0;
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_tag_q   <= '0;
            out_pfx_q   <= 1'b0;
            ovw_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prefix_q    <= prefix_d;
            out_valid_q <= out_valid_d;
            out_imm_q   <= out_imm_d;
            out_tag_q   <= out_tag_d;
            out_pfx_q   <= out_pfx_d;
            ovw_q       <= ovw_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_imm          = out_imm_q;
    assign out_tag          = out_tag_q;
    assign out_prefixed     = out_pfx_q;
    assign prefix_pending   = pending;
    assign prefix_overwrite = ovw_q;

endmodule

// File: tb/tb_cu_immediate_unit.sv
// Directed bench for cu_immediate_unit: a vector table for the streaming
// cases plus hand sequences for backpressure, flush and mid-run reset.
// A second DATA_W=32 instance shares the inputs with out_ready tied high.
module tb_cu_immediate_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [15:0] in_tag;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_imm;
    logic [15:0] out_tag;
    logic        out_prefixed;
    logic        prefix_pending;
    logic        prefix_overwrite;

    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] out_imm32;
    logic [15:0] out_tag32;
    logic        out_prefixed32;
    logic        prefix_pending32;
    logic        prefix_overwrite32;
    logic        out_ready32 = 1'b1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cu_immediate_unit #(.DATA_W(16), .TAG_W(16)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag), .out_prefixed(out_prefixed),
        .prefix_pending(prefix_pending), .prefix_overwrite(prefix_overwrite)
    );

    cu_immediate_unit #(.DATA_W(32), .TAG_W(16)) u_dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_prefixed(out_prefixed32),
        .prefix_pending(prefix_pending32), .prefix_overwrite(prefix_overwrite32)
    );

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  src;
        logic        exp_valid;
        logic [15:0] exp16;
        logic [31:0] exp32;
        logic        exp_pf;
        logic        exp_pend;
        logic        exp_ovw;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{16'h1F1C, 3'b000, 1'b1, 16'hFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h1F1C, 3'b001, 1'b1, 16'h00FF, 32'h000000FF, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'h1F1C, 3'b010, 1'b1, 16'h00FF, 32'h000000FF, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'h1F1C, 3'b011, 1'b1, 16'h00FF, 32'h000000FF, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{16'h0208, 3'b100, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{16'h1F1C, 3'b001, 1'b1, 16'h12FF, 32'h000012FF, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{16'h1F1C, 3'b111, 1'b1, 16'h0000, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'h0208, 3'b100, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{16'h1F1C, 3'b110, 1'b1, 16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{16'h1F1C, 3'b000, 1'b1, 16'h12FF, 32'h000012FF, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{16'h0208, 3'b100, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{16'h1F1C, 3'b100, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{16'h1F1C, 3'b001, 1'b1, 16'hFFFF, 32'h0000FFFF, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{16'h0480, 3'b100, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{16'h0004, 3'b000, 1'b1, 16'h2001, 32'hFFFC2001, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{16'h0080, 3'b010, 1'b1, 16'hFC00, 32'hFFFFFC00, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{16'h0480, 3'b100, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{16'h0004, 3'b011, 1'b1, 16'h0001, 32'h00210001, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        in_imm_src = '0; in_tag = '0; out_ready = 1'b1;
        step(); step();

        // Reset values
        check("rst_in_ready",   32'(in_ready), 32'd0);
        check("rst_out_valid",  32'(out_valid), 32'd0);
        check("rst_out_imm",    32'(out_imm), 32'd0);
        check("rst_out_tag",    32'(out_tag), 32'd0);
        check("rst_prefixed",   32'(out_prefixed), 32'd0);
        check("rst_pending",    32'(prefix_pending), 32'd0);
        check("rst_overwrite",  32'(prefix_overwrite), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Streaming table at full throughput
        for (int i = 0; i < 18; i++) begin
            in_valid   = 1'b1;
            in_instr   = vecs[i].instr;
            in_imm_src = vecs[i].src;
            in_tag     = 16'(16'h0100 + i);
            step();
            check($sformatf("v%0d_valid", i),   32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_pending", i), 32'(prefix_pending), 32'(vecs[i].exp_pend));
            check($sformatf("v%0d_ovw", i),     32'(prefix_overwrite), 32'(vecs[i].exp_ovw));
            check($sformatf("v%0d_valid32", i), 32'(out_valid32), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_imm", i),   32'(out_imm), 32'(vecs[i].exp16));
                check($sformatf("v%0d_tag", i),   32'(out_tag), 32'(16'h0100 + i));
                check($sformatf("v%0d_pf", i),    32'(out_prefixed), 32'(vecs[i].exp_pf));
                check($sformatf("v%0d_imm32", i), out_imm32, vecs[i].exp32);
            end
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: A accepted, B held off for 5 cycles, then both flow once
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 16'h1F1C; in_imm_src = 3'b000; in_tag = 16'h00A1;
        step();
        in_imm_src = 3'b001; in_tag = 16'h00B2;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("hold%0d_valid", c),    32'(out_valid), 32'd1);
            check($sformatf("hold%0d_imm", c),      32'(out_imm), 32'hFFFF);
            check($sformatf("hold%0d_tag", c),      32'(out_tag), 32'h00A1);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("release_valid", 32'(out_valid), 32'd1);
        check("release_imm",   32'(out_imm), 32'h00FF);
        check("release_tag",   32'(out_tag), 32'h00B2);
        step();
        check("release_no_dup", 32'(out_valid), 32'd0);

        // Flush drops the instruction and the pending prefix
        in_valid = 1'b1; in_instr = 16'h0208; in_imm_src = 3'b100; in_tag = 16'h00C0;
        step();
        check("flush_pre_pending", 32'(prefix_pending), 32'd1);
        flush = 1'b1; in_instr = 16'h1F1C; in_imm_src = 3'b001; in_tag = 16'h00C1;
        step();
        flush = 1'b0;
        check("flush_valid",   32'(out_valid), 32'd0);
        check("flush_pending", 32'(prefix_pending), 32'd0);
        in_tag = 16'h00C3;
        step();
        in_valid = 1'b0;
        check("after_flush_valid", 32'(out_valid), 32'd1);
        check("after_flush_imm",   32'(out_imm), 32'h00FF);
        check("after_flush_pf",    32'(out_prefixed), 32'd0);
        check("after_flush_tag",   32'(out_tag), 32'h00C3);

        // Reset while an output is held and a prefix is pending
        in_valid = 1'b1; in_instr = 16'h0208; in_imm_src = 3'b100; in_tag = 16'h00D0;
        step();
        in_instr = 16'h1F1C; in_imm_src = 3'b101; in_tag = 16'h00D1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("pre_rst_valid",   32'(out_valid), 32'd1);
        check("pre_rst_tag",     32'(out_tag), 32'h00D1);
        check("pre_rst_pending", 32'(prefix_pending), 32'd1);
        step();
        check("pre_rst_hold",    32'(out_valid), 32'd1);
        reset = 1'b1;
        step();
        check("mid_rst_valid",    32'(out_valid), 32'd0);
        check("mid_rst_imm",      32'(out_imm), 32'd0);
        check("mid_rst_tag",      32'(out_tag), 32'd0);
        check("mid_rst_pending",  32'(prefix_pending), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0; out_ready = 1'b1;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cu_immediate_unit.md
Name: cu_immediate_unit

Overview:
- Pipelined immediate generator for the 16-bit control unit. Extracts the 8-bit or 11-bit immediate from an instruction, sign- or zero-extends it to DATA_W, and registers the result with a valid/ready handshake.
- Adds a prefix mode: a prefix instruction supplies 11 upper bits, which are concatenated onto the next instruction's immediate, so wide constants can be built.
- Sits between instruction fetch/decode and the operand mux.

Parameters:
- DATA_W, 16: output immediate width; legal range 16..32.
- TAG_W, 16: width of the sideband tag (for example a PC) carried alongside each instruction.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discards the output register and any pending prefix.
- in_valid  in  1  instruction presented.
- in_ready  out  1  unit can accept an instruction.
- in_instr  in  16  instruction word.
- in_imm_src  in  3  immediate mode (see Behaviour).
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  out_imm, out_tag and out_prefixed are valid.
- out_ready  in  1  consumer accepts the output.
- out_imm  out  DATA_W  extended immediate.
- out_tag  out  TAG_W  tag of the producing instruction.
- out_prefixed  out  1  out_imm includes prefix bits.
- prefix_pending  out  1  a prefix is stored and waiting to be consumed.
- prefix_overwrite  out  1  one-cycle pulse: a new prefix replaced an unconsumed prefix.

Behaviour:
- Field extraction:
  - imm8 = {in_instr[12:8], in_instr[4:2]}.
  - imm11 = {in_instr[7:5], in_instr[12:8], in_instr[4:2]}.
- in_imm_src modes:
  - 000: sign-extend imm8.
  - 001: zero-extend imm8.
  - 010: sign-extend imm11.
  - 011: zero-extend imm11.
  - 100: PREFIX.
  - 101, 110, 111: reserved; output 0 and leave the prefix untouched.
- Accept condition: accept = in_valid && in_ready.
- Ready rule: in_ready = !out_valid || out_ready (one-stage pipeline). in_ready is 0 during reset.
- Latency: an accepted non-PREFIX instruction appears on out_imm exactly 1 cycle later.
- Output hold: the output fields stay stable while out_valid && !out_ready.
- Throughput: 1 instruction per cycle when out_ready = 1.
- PREFIX accepted:
  - Stores imm11 in an 11-bit prefix register and sets prefix_pending.
  - Produces no output; out_valid clears if the old output is consumed that cycle.
  - If prefix_pending was already 1, the new prefix replaces the old one and prefix_overwrite pulses for 1 cycle.
- Non-PREFIX accepted while prefix_pending = 1:
  - raw = {prefix, immN}: 19 bits for modes 000/001, 22 bits for modes 010/011.
  - raw is extended per mode (sign from the prefix MSB, or zero), then the low DATA_W bits are taken.
  - out_prefixed = 1 and prefix_pending clears.
- Non-PREFIX accepted with no prefix pending: raw = immN, extended to DATA_W, out_prefixed = 0.
- Reserved mode accepted: out_imm = 0, out_prefixed = 0, out_valid = 1, prefix state unchanged.
- flush (priority over accept):
  - Next cycle: out_valid = 0, prefix_pending = 0, prefix_overwrite = 0.
  - An instruction presented in the flush cycle is dropped; in_ready may still read 1.
- Reset values: out_valid = 0, out_imm = 0, out_tag = 0, out_prefixed = 0, prefix_pending = 0, prefix register = 0, prefix_overwrite = 0.
- Reset mid-operation discards a held output and any pending prefix.
- State machine:
  - States: IDLE (no prefix) and PREFIXED.
  - IDLE to PREFIXED on an accepted PREFIX.
  - PREFIXED to IDLE on an accepted mode 000–011, or on flush/reset.
  - PREFIXED stays PREFIXED on an accepted PREFIX (overwrite) or on a reserved mode.
- Simultaneous events: when the output is consumed and a new instruction is accepted in the same cycle, the output register updates the next cycle with no bubble.

Test Plan:
- DATA_W=16, out_ready=1. Send in_instr=0x1F1C in modes 000, 001, 010, 011 -> out_imm = 0xFFFF, 0x00FF, 0x00FF, 0x00FF respectively, each 1 cycle after accept, out_prefixed=0.
- PREFIX in_instr=0x0208 (prefix=0x012), then mode 001 with 0x1F1C -> no output for the prefix; out_imm=0x12FF, out_prefixed=1, prefix_pending 1 then 0.
- Two back-to-back PREFIX (0x0208, then 0x1F1C) -> prefix_overwrite=1 for exactly 1 cycle. A following mode 001 with 0x1F1C -> out_imm=0xFFFF (low 16 bits of {0x0FF, 0xFF}).
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0; out_imm and out_tag stay stable; no instruction lost or duplicated after release.
- PREFIX, then flush asserted together with a mode 001 instruction -> instruction dropped; prefix_pending=0; a later mode 001 with 0x1F1C gives 0x00FF, out_prefixed=0.
- Reset asserted while out_valid=1 and prefix pending -> next cycle out_valid=0, out_imm=0, prefix_pending=0. Also verify DATA_W=32 with mode 010 and imm11=0x400 -> out_imm=0xFFFFFC00.
